// File: rtl/dmx_frame_sequencer.sv
// DMX512 frame scheduler: break, mark-after-break, start code, then slot bytes
// fetched from a double-banked channel RAM, repeated on a fixed frame period.
//
// state  | meaning
// IDLE   | line at mark, waiting for enable
// BREAK  | line forced low for BREAK_CYCLES
// MAB    | mark-after-break for MAB_CYCLES
// START  | start code offered to serializer
// FETCH  | RAM read strobe for current slot
// LOAD   | RAM data captured into tx_data
// SEND   | slot byte offered to serializer
// HOLD   | pad out the remainder of the frame period
module dmx_frame_sequencer #(
  parameter int BREAK_CYCLES = 25,
  parameter int MAB_CYCLES   = 3,
  parameter int FRAME_CYCLES = 82500,
  parameter int NUM_CHANNELS = 512
) (
  input  logic       dmxclk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] start_code,
  input  logic       commit,
  output logic       commit_ack,
  output logic       bank_sel,
  output logic       mem_rd,
  output logic [8:0] mem_addr,
  input  logic [7:0] mem_data,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       line_break,
  output logic       frame_done,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_BREAK, S_MAB, S_START, S_FETCH, S_LOAD, S_SEND, S_HOLD
  } state_t;

  localparam logic [16:0] FRAME_LAST = 17'(FRAME_CYCLES - 1);
  localparam logic [8:0]  SLOT_LAST  = 9'(NUM_CHANNELS - 1);
  localparam logic [15:0] BREAK_LOAD = 16'(BREAK_CYCLES - 1);
  localparam logic [15:0] MAB_LOAD   = 16'(MAB_CYCLES - 1);

  state_t      state;
  logic [16:0] frame_cnt;
  logic [15:0] timer;
  logic [8:0]  slot;
  logic [7:0]  sc_latch;
  logic        pending;
  logic        break_entry;

  // enable is only looked at on frame boundaries
  always_comb begin
    break_entry = 1'b0;
    if (state == S_IDLE && enable)
      break_entry = 1'b1;
    else if (state == S_HOLD && frame_cnt == FRAME_LAST && enable)
      break_entry = 1'b1;
  end

  always_ff @(posedge dmxclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      frame_cnt  <= '0;
      timer      <= '0;
      slot       <= '0;
      sc_latch   <= '0;
      pending    <= 1'b0;
      commit_ack <= 1'b0;
      bank_sel   <= 1'b0;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      line_break <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      commit_ack <= 1'b0;
      frame_done <= 1'b0;

      // saturating counter lets an overrun frame leave HOLD immediately
      if (break_entry)
        frame_cnt <= '0;
      else if (state != S_IDLE && frame_cnt != FRAME_LAST)
        frame_cnt <= frame_cnt + 17'd1;

      if (break_entry) begin
        sc_latch   <= start_code;
        timer      <= BREAK_LOAD;
        line_break <= 1'b1;
        busy       <= 1'b1;
        state      <= S_BREAK;
        if (pending) begin
          bank_sel   <= ~bank_sel;
          commit_ack <= 1'b1;
        end
        // a commit landing on the swap edge waits for the following frame
        pending <= commit;
      end else begin
        if (commit)
          pending <= 1'b1;
        case (state)
          S_IDLE: state <= S_IDLE;
          S_BREAK: begin
            if (timer == 16'd0) begin
              line_break <= 1'b0;
              timer      <= MAB_LOAD;
              state      <= S_MAB;
            end else begin
              timer <= timer - 16'd1;
            end
          end
          S_MAB: begin
            if (timer == 16'd0) begin
              tx_data  <= sc_latch;
              tx_valid <= 1'b1;
              state    <= S_START;
            end else begin
              timer <= timer - 16'd1;
            end
          end
          S_START: begin
            if (tx_ready) begin
              tx_valid <= 1'b0;
              slot     <= '0;
              mem_rd   <= 1'b1;
              mem_addr <= '0;
              state    <= S_FETCH;
            end
          end
          S_FETCH: begin
            mem_rd <= 1'b0;
            state  <= S_LOAD;
          end
          S_LOAD: begin
            tx_data  <= mem_data;
            tx_valid <= 1'b1;
            state    <= S_SEND;
          end
          S_SEND: begin
            if (tx_ready) begin
              tx_valid <= 1'b0;
              if (slot == SLOT_LAST) begin
                frame_done <= 1'b1;
                state      <= S_HOLD;
              end else begin
                slot     <= slot + 9'd1;
                mem_rd   <= 1'b1;
                mem_addr <= slot + 9'd1;
                state    <= S_FETCH;
              end
            end
          end
          S_HOLD: begin
            if (frame_cnt == FRAME_LAST) begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/dmx_frame_sequencer.md
Name: dmx_frame_sequencer

Overview:
- Schedules complete DMX512 frames for the universe output: break, mark-after-break, start code, then NUM_CHANNELS slot bytes.
- Fetches slot bytes from a double-banked channel RAM and hands them to the downstream byte serializer over a valid/ready handshake.
- Enforces a fixed frame period.
- Swaps the RAM bank the host writes into only on frame boundaries, so a frame never mixes old and new channel data.

Parameters:
- BREAK_CYCLES, 25, break length in dmxclk cycles (4 us/cycle, 100 us).
- MAB_CYCLES, 3, mark-after-break length in dmxclk cycles (12 us).
- FRAME_CYCLES, 82500, frame period in dmxclk cycles, measured from break start to next break start.
- NUM_CHANNELS, 512, slots per frame; legal range 1..512.

Ports:
- dmxclk  in  1  single clock, 250 kHz (4 us).
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  run frames; sampled only at frame boundaries.
- start_code  in  8  start code byte; sampled at break entry.
- commit  in  1  one-cycle host request to swap banks at the next frame boundary.
- commit_ack  out  1  one-cycle pulse when the requested swap takes effect.
- bank_sel  out  1  bank currently read by the sequencer; the host writes !bank_sel.
- mem_rd  out  1  channel RAM read strobe.
- mem_addr  out  9  slot index 0..NUM_CHANNELS-1.
- mem_data  in  8  RAM read data, valid exactly 1 cycle after mem_rd.
- tx_data  out  8  byte to serializer.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  serializer accepts the byte when tx_valid&&tx_ready.
- line_break  out  1  1 = serializer forces line low (break); 0 = line is mark or serializer-driven.
- frame_done  out  1  one-cycle pulse when the last slot byte is accepted.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async assert, sync deassert): every output 0, bank_sel=0, pending commit cleared, state IDLE. Reset mid-frame aborts immediately; the line returns to mark (line_break=0).
- States and transitions:
  - IDLE: if enable, go to BREAK next cycle; otherwise stay.
  - BREAK: line_break=1 for exactly BREAK_CYCLES cycles. On the entry cycle, the frame counter clears to 0, start_code is latched, and any pending commit is applied.
  - MAB: line_break=0 for MAB_CYCLES cycles.
  - START: tx_data=latched start code, tx_valid=1; hold until tx_ready, then go to FETCH with slot=0.
  - FETCH: mem_rd=1, mem_addr=slot for one cycle, then go to LOAD.
  - LOAD: capture mem_data into tx_data, go to SEND.
  - SEND: tx_valid=1, tx_data stable until accepted. On acceptance, if slot==NUM_CHANNELS-1, pulse frame_done and go to HOLD; else slot+1, go to FETCH.
  - HOLD: wait until frame counter==FRAME_CYCLES-1. Then go to BREAK if enable, else IDLE.
- Frame counter: 17 bits, increments every cycle outside IDLE and saturates at FRAME_CYCLES-1. If the frame overruns (a stalled serializer), HOLD exits on the cycle after entry. No truncation, no error flag.
- tx_valid never drops before acceptance. tx_data and tx_valid change only after a handshake or on state entry.
- Commit handling:
  - commit sets a pending flag; repeated commits while pending merge into one.
  - At BREAK entry with pending=1: bank_sel toggles, commit_ack pulses that same cycle, and pending clears.
  - If commit and BREAK entry coincide, the commit is applied at the following frame's break.
  - Commits in IDLE stay pending until the next BREAK.
- enable deasserted mid-frame: the current frame completes in full, then IDLE.
- mem_addr holds its last value when mem_rd=0.

Test Plan:
- Reset then enable=1, tx_ready=1, NUM_CHANNELS=4, FRAME_CYCLES=60, start_code=0x00 -> line_break high cycles 0..24, low 25..27; bytes 0x00 then RAM[0..3] accepted in order; next line_break rises at cycle 60.
- tx_ready held low 5 cycles during slot 2 -> tx_valid and tx_data stable for the whole stall; no skipped or duplicated slot; with FRAME_CYCLES=40, next break starts the cycle after HOLD entry.
- commit pulsed mid-frame twice -> exactly one commit_ack, coincident with next BREAK entry; bank_sel 0→1; the following frame reads only bank 1 data.
- commit asserted on the BREAK entry cycle -> bank_sel unchanged that frame; toggles and acks at the next break.
- enable dropped during slot 1 -> frame finishes all slots, frame_done pulses, state IDLE, busy=0, line_break=0.
- rst_n asserted during BREAK -> line_break, tx_valid, and mem_rd go 0 asynchronously; after release with enable=1, a full 25-cycle break is produced.
